// File: rtl/dpsram_clr.sv
// Single-clock true dual-port RAM, registered reads, port-0 priority.
// Built-in clear sweep; optional bit-write masks.
module dpsram_clr #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 196,
  parameter     MEMFILE    = ""
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic                  i_write0,
`ifdef DPSRAM_CLR_WMASK_EN
  input  logic [DATA_WIDTH-1:0] i_wmask0,
`endif
  output logic [DATA_WIDTH-1:0] o_data0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_data1,
  input  logic                  i_write1,
`ifdef DPSRAM_CLR_WMASK_EN
  input  logic [DATA_WIDTH-1:0] i_wmask1,
`endif
  output logic [DATA_WIDTH-1:0] o_data1,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_fill,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_collision
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH-1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] fill_q;

  logic                  in0, in1, clearing, same;
  logic                  we0, we1, dual, coll_nxt;
  logic [DATA_WIDTH-1:0] m0, m1, old0, old1;
  logic [DATA_WIDTH-1:0] new0, new1, mrg, wd0, wd1;
  logic [DATA_WIDTH-1:0] rd0_nxt, rd1_nxt;

`ifdef DPSRAM_CLR_WMASK_EN
  assign m0 = i_wmask0;
  assign m1 = i_wmask1;
`else
  assign m0 = '1;
  assign m1 = '1;
`endif

  assign in0      = {1'b0, i_addr0} < DEPTH_W;
  assign in1      = {1'b0, i_addr1} < DEPTH_W;
  assign clearing = (state == CLEAR);
  assign same     = (i_addr0 == i_addr1);
  assign we0      = i_write0 & in0 & ~clearing;
  assign we1      = i_write1 & in1 & ~clearing;
  assign dual     = we0 & we1 & same;
  assign coll_nxt = dual & ((m0 & m1) != '0);

  assign old0 = in0 ? mem[i_addr0] : '0;
  assign old1 = in1 ? mem[i_addr1] : '0;

  assign new0 = (old0 & ~m0) | (i_data0 & m0);
  assign new1 = (old1 & ~m1) | (i_data1 & m1);
  assign mrg  = (old0 & ~(m0 | m1))
              | (i_data1 & m1 & ~m0)
              | (i_data0 & m0);
  assign wd0  = dual ? mrg : new0;
  assign wd1  = dual ? mrg : new1;

  always_comb begin
    rd0_nxt = old0;
    if (!in0)            rd0_nxt = '0;
    else if (we0)        rd0_nxt = wd0;
    else if (we1 & same) rd0_nxt = wd1;
  end

  always_comb begin
    rd1_nxt = old1;
    if (!in1)            rd1_nxt = '0;
    else if (we0 & same) rd1_nxt = wd0;
    else if (we1)        rd1_nxt = wd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (clearing) begin
        mem[cnt] <= fill_q;
      end else begin
        if (we1) mem[i_addr1] <= wd1;
        if (we0) mem[i_addr0] <= wd0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_data0     <= '0;
      o_data1     <= '0;
      o_collision <= 1'b0;
    end else begin
      o_data0     <= rd0_nxt;
      o_data1     <= rd1_nxt;
      o_collision <= coll_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_clear) state_nxt = CLEAR;
      CLEAR:   if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state == CLEAR);
    o_done = (state == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      fill_q <= '0;
    end else if (state == IDLE && i_clear) begin
      cnt    <= '0;
      fill_q <= i_fill;
    end else if (clearing) begin
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dpsram_clr.sv
// Randomised self-checking bench for dpsram_clr against an array model.
// Mask test compiles in when DPSRAM_CLR_WMASK_EN is defined.
module tb_dpsram_clr;

   localparam int DW    = 2;
   localparam int AW    = 8;
   localparam int DEPTH = 196;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] a0 = '0, a1 = '0;
   logic [DW-1:0] d0 = '0, d1 = '0;
   logic          w0 = 1'b0, w1 = 1'b0;
   logic [DW-1:0] q0, q1;
   logic          clr = 1'b0;
   logic [DW-1:0] fill = '0;
   logic          busy, done, coll;
`ifdef DPSRAM_CLR_WMASK_EN
   logic [DW-1:0] wm0 = '1, wm1 = '1;
`endif

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] mm [DEPTH];
   logic [DW-1:0] e0, e1;
   logic          ec;

   always #5 clk = ~clk;

   dpsram_clr #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .MEMFILE("")
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_addr0(a0), .i_data0(d0), .i_write0(w0),
`ifdef DPSRAM_CLR_WMASK_EN
      .i_wmask0(wm0),
`endif
      .o_data0(q0),
      .i_addr1(a1), .i_data1(d1), .i_write1(w1),
`ifdef DPSRAM_CLR_WMASK_EN
      .i_wmask1(wm1),
`endif
      .o_data1(q1),
      .i_clear(clr), .i_fill(fill),
      .o_busy(busy), .o_done(done), .o_collision(coll)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One user cycle: model predicts outputs from the word-level rules
   task automatic cycle(input logic [AW-1:0] x0, input logic [DW-1:0] y0,
                        input logic v0, input logic [AW-1:0] x1,
                        input logic [DW-1:0] y1, input logic v1);
      bit ok0, ok1;
      ok0 = (int'(x0) < DEPTH);
      ok1 = (int'(x1) < DEPTH);
      if (!ok0)                 e0 = '0;
      else if (v0)              e0 = y0;
      else if (v1 && x1 == x0)  e0 = y1;
      else                      e0 = mm[x0];
      if (!ok1)                 e1 = '0;
      else if (v0 && x0 == x1)  e1 = y0;
      else if (v1)              e1 = y1;
      else                      e1 = mm[x1];
      ec = v0 && v1 && ok0 && x0 == x1;
      if (v1 && ok1) mm[x1] = y1;
      if (v0 && ok0) mm[x0] = y0;
      a0 = x0; d0 = y0; w0 = v0;
      a1 = x1; d1 = y1; w1 = v1;
      tick();
      w0 = 1'b0; w1 = 1'b0;
   endtask

   task automatic read_all();
      for (int a = 0; a < DEPTH; a++) begin
         cycle(AW'(a), '0, 1'b0, AW'(DEPTH-1-a), '0, 1'b0);
         checks += 2;
         if (q0 !== e0) begin
            failures++;
            $display("FAIL readall0 a=%0d got=%0h exp=%0h", a, q0, e0);
         end
         if (q1 !== e1) begin
            failures++;
            $display("FAIL readall1 a=%0d got=%0h exp=%0h", DEPTH-1-a, q1, e1);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      checks += 5;
      if (q0 !== '0)   begin failures++; $display("FAIL rst_q0 got=%0h exp=0", q0); end
      if (q1 !== '0)   begin failures++; $display("FAIL rst_q1 got=%0h exp=0", q1); end
      if (busy !== 0)  begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
      if (done !== 0)  begin failures++; $display("FAIL rst_done got=%0b exp=0", done); end
      if (coll !== 0)  begin failures++; $display("FAIL rst_coll got=%0b exp=0", coll); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_clear();
      int n;
      clr = 1'b1; fill = 2'b01;
      tick();
      clr = 1'b0;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL clr_start busy=%0b exp=1", busy); end
      n = 0;
      while (busy === 1'b1 && n < 1000) begin
         if (n == 10) begin a0 = 7; d0 = 2'b10; w0 = 1'b1; end
         if (n == 20) begin clr = 1'b1; fill = 2'b10; end
         checks++;
         if (done !== 1'b0) begin failures++; $display("FAIL clr_early_done n=%0d got=%0b exp=0", n, done); end
         tick();
         w0 = 1'b0; clr = 1'b0;
         n++;
      end
      checks += 3;
      if (n != DEPTH) begin failures++; $display("FAIL clr_busy_len got=%0d exp=%0d", n, DEPTH); end
      if (done !== 1'b1) begin failures++; $display("FAIL clr_done got=%0b exp=1", done); end
      tick();
      if (done !== 1'b0) begin failures++; $display("FAIL clr_done_pulse got=%0b exp=0", done); end
      for (int a = 0; a < DEPTH; a++) mm[a] = 2'b01;
      read_all();
   endtask

   task automatic test_directed();
      cycle(5, 2'b10, 1'b1, 0, '0, 1'b0);
      checks++;
      if (q0 !== 2'b10) begin failures++; $display("FAIL wfirst got=%0h exp=2", q0); end
      cycle(0, '0, 1'b0, 5, '0, 1'b0);
      checks++;
      if (q1 !== 2'b10) begin failures++; $display("FAIL xread got=%0h exp=2", q1); end
      cycle(20, 2'b01, 1'b1, 20, 2'b11, 1'b1);
      checks += 3;
      if (q0 !== 2'b01) begin failures++; $display("FAIL coll_q0 got=%0h exp=1", q0); end
      if (q1 !== 2'b01) begin failures++; $display("FAIL coll_q1 got=%0h exp=1", q1); end
      if (coll !== 1'b1) begin failures++; $display("FAIL coll_flag got=%0b exp=1", coll); end
      cycle(20, '0, 1'b0, 21, '0, 1'b0);
      checks += 2;
      if (coll !== 1'b0) begin failures++; $display("FAIL coll_pulse got=%0b exp=0", coll); end
      if (q0 !== 2'b01) begin failures++; $display("FAIL coll_mem got=%0h exp=1", q0); end
      cycle(0, '0, 1'b0, 200, 2'b11, 1'b1);
      checks += 2;
      if (q1 !== '0) begin failures++; $display("FAIL oob_wr_rd got=%0h exp=0", q1); end
      if (coll !== 1'b0) begin failures++; $display("FAIL oob_flag got=%0b exp=0", coll); end
      cycle(200, '0, 1'b0, 0, '0, 1'b0);
      checks++;
      if (q0 !== '0) begin failures++; $display("FAIL oob_rd got=%0h exp=0", q0); end
      read_all();
   endtask

   task automatic test_random();
      logic [AW-1:0] x0, x1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            x0 = AW'($urandom_range(0, 7));
            x1 = AW'($urandom_range(0, 7));
         end else begin
            x0 = AW'($urandom_range(0, DEPTH + 20));
            x1 = AW'($urandom_range(0, DEPTH + 20));
         end
         cycle(x0, DW'($urandom), 1'($urandom), x1, DW'($urandom), 1'($urandom));
         checks += 3;
         if (q0 !== e0) begin failures++; $display("FAIL rnd_q0 i=%0d got=%0h exp=%0h", i, q0, e0); end
         if (q1 !== e1) begin failures++; $display("FAIL rnd_q1 i=%0d got=%0h exp=%0h", i, q1, e1); end
         if (coll !== ec) begin failures++; $display("FAIL rnd_coll i=%0d got=%0b exp=%0b", i, coll, ec); end
      end
      read_all();
   endtask

   task automatic test_clear_reset();
      clr = 1'b1; fill = 2'b11;
      tick();
      clr = 1'b0;
      for (int k = 0; k < 50; k++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy); end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (done !== 1'b0) begin failures++; $display("FAIL abort_done k=%0d got=%0b exp=0", k, done); end
         tick();
      end
      for (int a = 0; a < 50; a++) mm[a] = 2'b11;
      read_all();
   endtask

`ifdef DPSRAM_CLR_WMASK_EN
   task automatic test_wmask();
      cycle(3, 2'b00, 1'b1, 0, '0, 1'b0);
      wm0 = 2'b10;
      a0 = 3; d0 = 2'b11; w0 = 1'b1;
      tick();
      w0 = 1'b0; wm0 = '1;
      mm[3] = 2'b10;
      checks++;
      if (q0 !== 2'b10) begin failures++; $display("FAIL wmask_wf got=%0h exp=2", q0); end
      cycle(0, '0, 1'b0, 3, '0, 1'b0);
      checks++;
      if (q1 !== 2'b10) begin failures++; $display("FAIL wmask_rd got=%0h exp=2", q1); end
   endtask
`endif

   initial begin
      test_reset();
      test_clear();
      test_directed();
      test_random();
      test_clear_reset();
`ifdef DPSRAM_CLR_WMASK_EN
      test_wmask();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
